// File: rtl/riscv_dmem_responder.sv
// Data-memory responder: one outstanding load/store at a time over a
// valid/ready request channel, performed on an internal word-addressed RAM,
// with the response returned LATENCY cycles later over a valid/ready
// response channel.
//
// Handshake rules: a transfer happens on a rising edge where valid and ready
// are both 1. The sender holds valid and its payload stable until that edge.
// The receiver may raise or lower ready at any time. This block only raises
// req_ready in IDLE. Once rsp_valid is up, rsp_valid, rsp_rdata and rsp_err
// are held until the rsp_ready edge.
module riscv_dmem_responder #(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          LATENCY   = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [1:0]  state_dbg
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  lat_cnt;
    logic [31:0] mem [DEPTH];

    logic [31:0]      offset;
    logic [31:0]      word_off;
    logic [IDX_W-1:0] idx;
    logic             fault;
    logic             accept;

    // Offset is computed as unsigned 32-bit. An address below the base wraps
    // to a huge offset, but the explicit below-base test catches it regardless.
    assign offset   = req_addr - BASE_ADDR;
    assign word_off = offset >> 2;
    assign idx      = word_off[IDX_W-1:0];
    assign fault    = (req_addr[1:0] != 2'b00)
                   || (req_addr < BASE_ADDR)
                   || (word_off >= 32'(DEPTH));
    assign accept   = (state == IDLE) && req_valid;

    assign req_ready = (state == IDLE);
    assign state_dbg = state;

    // Stores commit on their accept edge, so a following load sees the data.
    // Reset blocks the write, so a request accepted on a reset edge never lands.
    always_ff @(posedge clock) begin
        if (!reset && accept && !fault && req_we) begin
            for (int b = 0; b < 4; b++) begin
                if (req_be[b]) begin
                    mem[idx][8*b +: 8] <= req_wdata[8*b +: 8];
                end
            end
        end
    end

    // Request/response sequencer. The response payload is captured at the
    // accept edge and is held through WAIT and RESP. The counter is checked
    // before it is decremented, so rsp_valid is first sampled high LATENCY
    // edges after the accept edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
            lat_cnt   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        rsp_err   <= fault;
                        rsp_rdata <= (fault || req_we) ? 32'h0 : mem[idx];
                        if (LATENCY <= 1) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                        end else begin
                            state   <= WAIT;
                            lat_cnt <= 4'(LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    if (lat_cnt <= 4'd1) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        lat_cnt   <= 4'd0;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= 32'h0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    rsp_rdata <= 32'h0;
                    rsp_err   <= 1'b0;
                    lat_cnt   <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_dmem_responder.sv
// Bench for riscv_dmem_responder. It builds four instances with different
// latency, depth and base settings, drives directed scenarios, and then drives
// random traffic. The random traffic is checked against a byte-level memory
// model that is kept in associative arrays.
module tb_riscv_dmem_responder;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    // ---------------- per-instance configuration ----------------
    function automatic int lat_of(input int d);
        case (d)
            0:       return 1;
            1:       return 3;
            2:       return 4;
            default: return 2;
        endcase
    endfunction

    function automatic int dep_of(input int d);
        return (d == 3) ? 16 : 1024;
    endfunction

    function automatic logic [31:0] base_of(input int d);
        return (d == 3) ? 32'h8000_0000 : 32'h0000_0000;
    endfunction

    // ---------------- DUT signals ----------------
    logic [3:0]  req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
    logic [31:0] req_addr  [4];
    logic [31:0] req_wdata [4];
    logic [31:0] rsp_rdata [4];
    logic [3:0]  req_be    [4];
    logic [1:0]  state_dbg [4];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        riscv_dmem_responder #(
            .DEPTH     (dep_of(g)),
            .BASE_ADDR (base_of(g)),
            .LATENCY   (lat_of(g))
        ) u_dut (
            .clock     (clock),
            .reset     (reset),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_addr  (req_addr[g]),
            .req_we    (req_we[g]),
            .req_be    (req_be[g]),
            .req_wdata (req_wdata[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_ready (rsp_ready[g]),
            .rsp_rdata (rsp_rdata[g]),
            .rsp_err   (rsp_err[g]),
            .state_dbg (state_dbg[g])
        );
    end

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;

    // Results of the most recent access() call.
    logic [31:0] r_rdata;
    logic        r_err;
    int          r_lat;
    logic        r_busy_ready;
    logic        r_idle_ok;

    // ---------------- reference model ----------------
    logic [31:0] mm [int];
    logic [3:0]  kn [int];

    function automatic bit m_fault(input int d, input logic [31:0] a);
        longint ua = longint'(a);
        longint ub = longint'(base_of(d));
        if (a[1:0] != 2'b00) return 1'b1;
        if (ua < ub) return 1'b1;
        return ((ua - ub) / 4) >= longint'(dep_of(d));
    endfunction

    function automatic int m_key(input int d, input logic [31:0] a);
        return d * 4096 + int'((a - base_of(d)) >> 2);
    endfunction

    task automatic m_apply(input int d, input logic we, input logic [31:0] a,
                           input logic [3:0] be, input logic [31:0] wd,
                           output logic [31:0] exp_rd, output logic exp_err);
        int k;
        logic [31:0] cur;
        logic [3:0] km;
        exp_rd  = 32'h0;
        exp_err = m_fault(d, a);
        if (!exp_err) begin
            k = m_key(d, a);
            if (we) begin
                cur = mm.exists(k) ? mm[k] : 32'h0;
                km  = kn.exists(k) ? kn[k] : 4'h0;
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) begin
                        cur[8*b +: 8] = wd[8*b +: 8];
                        km[b] = 1'b1;
                    end
                end
                mm[k] = cur;
                kn[k] = km;
            end else begin
                exp_rd = mm.exists(k) ? mm[k] : 32'hx;
            end
        end
    endtask

    // ---------------- driver ----------------
    // Call at a falling edge. It presents one request with rsp_ready=1, waits
    // for acceptance and for the response, and returns at the falling edge
    // after the response handshake.
    task automatic access(input int d, input logic we, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wdata);
        int t;
        logic acc;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_be[d]    = be;
        req_wdata[d] = wdata;
        req_valid[d] = 1'b1;
        rsp_ready[d] = 1'b1;
        r_rdata = 32'h0; r_err = 1'b0; r_lat = 0; r_busy_ready = 1'b0; r_idle_ok = 1'b0;
        acc = 1'b0;
        t = 0;
        while (!acc && t < 50) begin
            acc = req_ready[d];
            @(posedge clock);
            @(negedge clock);
            t++;
        end
        req_valid[d] = 1'b0;
        n_checks++;
        if (!acc) begin
            $display("FAIL accept_timeout dut%0d: req_ready=%b, required 1 within 50 cycles", d, req_ready[d]);
            return;
        end
        n_pass++;
        r_lat = 1;
        while (!rsp_valid[d] && r_lat < 40) begin
            if (req_ready[d]) r_busy_ready = 1'b1;
            @(negedge clock);
            r_lat++;
        end
        n_checks++;
        if (!rsp_valid[d]) begin
            $display("FAIL rsp_timeout dut%0d: rsp_valid=%b, required 1 within 40 cycles", d, rsp_valid[d]);
            return;
        end
        n_pass++;
        if (req_ready[d]) r_busy_ready = 1'b1;
        r_rdata = rsp_rdata[d];
        r_err   = rsp_err[d];
        @(negedge clock);
        r_idle_ok = (rsp_valid[d] === 1'b0) && (rsp_rdata[d] === 32'h0)
                 && (rsp_err[d] === 1'b0) && (req_ready[d] === 1'b1);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        for (int d = 0; d < 4; d++) begin
            n_checks++;
            if ({rsp_valid[d], req_ready[d], rsp_err[d], rsp_rdata[d]} !== {1'b0, 1'b1, 1'b0, 32'h0})
                $display("FAIL reset_state dut%0d: valid/ready/err/rdata=%b/%b/%b/%h, required 0/1/0/00000000",
                         d, rsp_valid[d], req_ready[d], rsp_err[d], rsp_rdata[d]);
            else n_pass++;
        end
    endtask

    task automatic test_store_load();
        access(0, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF);
        n_checks++;
        if ({r_err, r_rdata, r_lat, r_idle_ok} !== {1'b0, 32'h0, 32'd1, 1'b1})
            $display("FAIL store_rsp: err=%b rdata=%h lat=%0d idle=%b, required 0 00000000 1 1", r_err, r_rdata, r_lat, r_idle_ok);
        else n_pass++;
        access(0, 1'b0, 32'h10, 4'h0, 32'h0);
        n_checks++;
        if ({r_err, r_rdata, r_lat} !== {1'b0, 32'hDEAD_BEEF, 32'd1})
            $display("FAIL load_after_store: err=%b rdata=%h lat=%0d, required 0 deadbeef 1", r_err, r_rdata, r_lat);
        else n_pass++;
    endtask

    task automatic test_partial_store();
        access(0, 1'b1, 32'h20, 4'hF, 32'h1122_3344);
        access(0, 1'b1, 32'h20, 4'b0101, 32'hAABB_CCDD);
        n_checks++;
        if ({r_err, r_rdata} !== {1'b0, 32'h0})
            $display("FAIL partial_store_rsp: err=%b rdata=%h, required 0 00000000", r_err, r_rdata);
        else n_pass++;
        access(0, 1'b0, 32'h20, 4'h0, 32'h0);
        n_checks++;
        if (r_rdata !== 32'h11BB_33DD)
            $display("FAIL partial_store_data: rdata=%h, required 11bb33dd", r_rdata);
        else n_pass++;
        access(0, 1'b1, 32'h20, 4'h0, 32'hFFFF_FFFF);
        access(0, 1'b0, 32'h20, 4'h0, 32'h0);
        n_checks++;
        if (r_rdata !== 32'h11BB_33DD)
            $display("FAIL be_zero_noop: rdata=%h, required 11bb33dd", r_rdata);
        else n_pass++;
    endtask

    task automatic test_latency();
        access(1, 1'b1, 32'h10, 4'hF, 32'h1234_5678);
        access(1, 1'b0, 32'h10, 4'h0, 32'h0);
        n_checks++;
        if ({r_lat, r_busy_ready, r_rdata, r_idle_ok} !== {32'd3, 1'b0, 32'h1234_5678, 1'b1})
            $display("FAIL latency3: lat=%0d ready_while_busy=%b rdata=%h idle=%b, required 3 0 12345678 1",
                     r_lat, r_busy_ready, r_rdata, r_idle_ok);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int t;
        access(0, 1'b1, 32'h30, 4'hF, 32'h0BAD_F00D);
        req_we[0] = 1'b0; req_addr[0] = 32'h30; req_be[0] = 4'h0; req_wdata[0] = 32'h0;
        req_valid[0] = 1'b1;
        rsp_ready[0] = 1'b0;
        t = 0;
        while (!req_ready[0] && t < 20) begin
            @(negedge clock);
            t++;
        end
        @(posedge clock);
        @(negedge clock);
        // Second request, a store, stays pending while the response is stalled.
        req_we[0] = 1'b1; req_addr[0] = 32'h34; req_be[0] = 4'hF; req_wdata[0] = 32'hCAFE_BABE;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({rsp_valid[0], req_ready[0], rsp_err[0], rsp_rdata[0]} !== {1'b1, 1'b0, 1'b0, 32'h0BAD_F00D})
                $display("FAIL backpressure_hold cycle%0d: valid/ready/err/rdata=%b/%b/%b/%h, required 1/0/0/0badf00d",
                         i, rsp_valid[0], req_ready[0], rsp_err[0], rsp_rdata[0]);
            else n_pass++;
            @(negedge clock);
        end
        rsp_ready[0] = 1'b1;
        @(negedge clock);
        n_checks++;
        if ({rsp_valid[0], req_ready[0]} !== 2'b01)
            $display("FAIL backpressure_release: valid/ready=%b/%b, required 0/1", rsp_valid[0], req_ready[0]);
        else n_pass++;
        @(negedge clock);
        req_valid[0] = 1'b0;
        n_checks++;
        if ({rsp_valid[0], req_ready[0], rsp_err[0], rsp_rdata[0]} !== {1'b1, 1'b0, 1'b0, 32'h0})
            $display("FAIL second_req_accept: valid/ready/err/rdata=%b/%b/%b/%h, required 1/0/0/00000000",
                     rsp_valid[0], req_ready[0], rsp_err[0], rsp_rdata[0]);
        else n_pass++;
        @(negedge clock);
        access(0, 1'b0, 32'h34, 4'h0, 32'h0);
        n_checks++;
        if (r_rdata !== 32'hCAFE_BABE)
            $display("FAIL second_req_data: rdata=%h, required cafebabe", r_rdata);
        else n_pass++;
    endtask

    task automatic test_faults();
        access(0, 1'b1, 32'hFFC, 4'hF, 32'h7777_7777);
        access(0, 1'b1, 32'h004, 4'hF, 32'h4444_4444);
        access(0, 1'b0, 32'h1000, 4'h0, 32'h0);
        n_checks++;
        if ({r_err, r_rdata, r_lat} !== {1'b1, 32'h0, 32'd1})
            $display("FAIL fault_load_range: err=%b rdata=%h lat=%0d, required 1 00000000 1", r_err, r_rdata, r_lat);
        else n_pass++;
        access(0, 1'b0, 32'h0002, 4'h0, 32'h0);
        n_checks++;
        if ({r_err, r_rdata} !== {1'b1, 32'h0})
            $display("FAIL fault_load_misaligned: err=%b rdata=%h, required 1 00000000", r_err, r_rdata);
        else n_pass++;
        access(0, 1'b1, 32'h1004, 4'hF, 32'hFFFF_FFFF);
        n_checks++;
        if ({r_err, r_rdata, r_idle_ok} !== {1'b1, 32'h0, 1'b1})
            $display("FAIL fault_store_range: err=%b rdata=%h idle=%b, required 1 00000000 1", r_err, r_rdata, r_idle_ok);
        else n_pass++;
        access(0, 1'b0, 32'hFFC, 4'h0, 32'h0);
        n_checks++;
        if ({r_err, r_rdata} !== {1'b0, 32'h7777_7777})
            $display("FAIL fault_ram_top: err=%b rdata=%h, required 0 77777777", r_err, r_rdata);
        else n_pass++;
        access(0, 1'b0, 32'h004, 4'h0, 32'h0);
        n_checks++;
        if ({r_err, r_rdata} !== {1'b0, 32'h4444_4444})
            $display("FAIL fault_ram_alias: err=%b rdata=%h, required 0 44444444", r_err, r_rdata);
        else n_pass++;
    endtask

    task automatic test_reset_mid_wait();
        logic seen;
        int t;
        seen = 1'b0;
        req_we[2] = 1'b1; req_addr[2] = 32'h40; req_be[2] = 4'hF; req_wdata[2] = 32'h5A5A_5A5A;
        req_valid[2] = 1'b1;
        rsp_ready[2] = 1'b1;
        t = 0;
        while (!req_ready[2] && t < 20) begin
            @(negedge clock);
            t++;
        end
        @(posedge clock);
        @(negedge clock);
        req_valid[2] = 1'b0;
        seen |= rsp_valid[2];
        @(negedge clock);
        seen |= rsp_valid[2];
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            seen |= rsp_valid[2];
            @(negedge clock);
        end
        n_checks++;
        if ({seen, req_ready[2]} !== 2'b01)
            $display("FAIL reset_mid_wait: rsp_valid_seen=%b req_ready=%b, required 0 1", seen, req_ready[2]);
        else n_pass++;
        access(2, 1'b0, 32'h40, 4'h0, 32'h0);
        n_checks++;
        if ({r_err, r_rdata, r_lat} !== {1'b0, 32'h5A5A_5A5A, 32'd4})
            $display("FAIL reset_store_kept: err=%b rdata=%h lat=%0d, required 0 5a5a5a5a 4", r_err, r_rdata, r_lat);
        else n_pass++;
    endtask

    task automatic test_random(input int d);
        logic [31:0] base, a, wd, exp_rd;
        logic [3:0] be;
        logic we, exp_err;
        int w, sel;
        base = base_of(d);
        // Preload words 0..7 and the last word so every later in-range load is known.
        for (int i = 0; i <= 8; i++) begin
            w  = (i == 8) ? dep_of(d) - 1 : i;
            a  = base + 32'(4 * w);
            wd = $urandom;
            m_apply(d, 1'b1, a, 4'hF, wd, exp_rd, exp_err);
            access(d, 1'b1, a, 4'hF, wd);
        end
        for (int n = 0; n < 40; n++) begin
            w   = $urandom_range(0, 8);
            if (w == 8) w = dep_of(d) - 1;
            a   = base + 32'(4 * w);
            sel = $urandom_range(0, 9);
            if (sel == 0) a = a + 32'($urandom_range(1, 3));
            else if (sel == 1) a = base + 32'(4 * dep_of(d)) + 32'(4 * $urandom_range(0, 3));
            else if (sel == 2) a = base - 32'(4 * $urandom_range(1, 4));
            we = 1'($urandom_range(0, 1));
            be = 4'($urandom_range(0, 15));
            wd = $urandom;
            m_apply(d, we, a, be, wd, exp_rd, exp_err);
            access(d, we, a, be, wd);
            n_checks++;
            if ({r_err, r_rdata} !== {exp_err, exp_rd})
                $display("FAIL random_rsp dut%0d op%0d addr=%h we=%b be=%h: err=%b rdata=%h, required %b %h",
                         d, n, a, we, be, r_err, r_rdata, exp_err, exp_rd);
            else n_pass++;
            n_checks++;
            if ({r_lat, r_busy_ready, r_idle_ok} !== {lat_of(d), 1'b0, 1'b1})
                $display("FAIL random_timing dut%0d op%0d: lat=%0d ready_while_busy=%b idle=%b, required %0d 0 1",
                         d, n, r_lat, r_busy_ready, r_idle_ok, lat_of(d));
            else n_pass++;
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_we    = '0;
        rsp_ready = '0;
        for (int d = 0; d < 4; d++) begin
            req_addr[d]  = 32'h0;
            req_wdata[d] = 32'h0;
            req_be[d]    = 4'h0;
        end
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        test_reset();
        test_store_load();
        test_partial_store();
        test_latency();
        test_backpressure();
        test_faults();
        test_reset_mid_wait();
        test_random(0);
        test_random(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Hard stop in case a scenario wedges outside a bounded wait.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion before it");
        $fatal(1, "watchdog");
    end

endmodule
